// File: rtl/bch_31_chien_search.sv
// ---------------------------------------------------------------------------
// bch_31_chien_search
//   Chien search stage of the BCH(31) decoder. Takes one error-locator pair
//   Lambda(x) = 1 + lambda1*x + lambda2*x^2 over GF(2^5) (x^5+x^2+1) and tests
//   every codeword position, one per clock, MSB position (30) first.
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   in_valid / in_ready  locator handshake; transfer when both are high on a
//                        rising edge. in_ready is high only while idle.
//   lambda1, lambda2     locator coefficients (x^1, x^2)
//   bit_valid            high for the 31 search cycles
//   bit_err, bit_pos     per-position error flag and position (30 .. 0)
//   out_valid            one-cycle pulse: err_vec / err_cnt / fail are final
//   err_vec              bit i set -> codeword bit i in error
//   err_cnt              number of roots found (0..2)
//   fail                 root count differs from the degree of Lambda
// ---------------------------------------------------------------------------
module bch_31_chien_search #(
    parameter int          N         = 31,
    parameter int          M         = 5,
    parameter logic [5:0]  PRIM_POLY = 6'h25
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [M-1:0] lambda1,
    input  logic [M-1:0] lambda2,
    output logic         bit_valid,
    output logic         bit_err,
    output logic [M-1:0] bit_pos,
    output logic         out_valid,
    output logic [N-1:0] err_vec,
    output logic [1:0]   err_cnt,
    output logic         fail
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Multiply by alpha: shift left and fold x^5 back in as x^2+1.
    function automatic logic [M-1:0] mul_a(input logic [M-1:0] a);
        return {a[M-2:0], 1'b0} ^ (a[M-1] ? PRIM_POLY[M-1:0] : '0);
    endfunction

    state_t         state_q;
    logic [M-1:0]   r1_q;       // lambda1 * alpha^(k+1)
    logic [M-1:0]   r2_q;       // lambda2 * alpha^(2(k+1))
    logic [M-1:0]   k_q;
    logic [1:0]     deg_q;
    logic [N-1:0]   err_vec_q;
    logic [1:0]     err_cnt_q;
    logic           fail_q;

    logic           hit;
    logic [N-1:0]   err_vec_d;
    logic [1:0]     err_cnt_d;
    logic [1:0]     deg_d;

    // Evaluating at alpha^(k+1) == alpha^-(30-k) walks positions 30 down to 0.
    assign hit       = (state_q == SEARCH) && ((M'(1) ^ r1_q ^ r2_q) == '0);

    assign in_ready  = (state_q == IDLE);
    assign bit_valid = (state_q == SEARCH);
    assign out_valid = (state_q == DONE);
    assign bit_err   = hit;
    assign bit_pos   = M'(N - 1) - k_q;
    assign err_vec   = err_vec_q;
    assign err_cnt   = err_cnt_q;
    assign fail      = fail_q;

    always_comb begin
        err_vec_d = err_vec_q;
        err_cnt_d = err_cnt_q;
        if (hit) begin
            err_vec_d = err_vec_q | (N'(1) << bit_pos);
            err_cnt_d = err_cnt_q + 2'd1;
        end
    end

    always_comb begin
        deg_d = 2'd0;
        if (lambda2 != '0)      deg_d = 2'd2;
        else if (lambda1 != '0) deg_d = 2'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            r1_q      <= '0;
            r2_q      <= '0;
            k_q       <= '0;
            deg_q     <= '0;
            err_vec_q <= '0;
            err_cnt_q <= '0;
            fail_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        r1_q      <= mul_a(lambda1);
                        r2_q      <= mul_a(mul_a(lambda2));
                        deg_q     <= deg_d;
                        err_vec_q <= '0;
                        err_cnt_q <= '0;
                        fail_q    <= 1'b0;
                        k_q       <= '0;
                        state_q   <= SEARCH;
                    end
                end
                SEARCH: begin
                    r1_q      <= mul_a(r1_q);
                    r2_q      <= mul_a(mul_a(r2_q));
                    err_vec_q <= err_vec_d;
                    err_cnt_q <= err_cnt_d;
                    k_q       <= k_q + M'(1);
                    if (k_q == M'(N - 1)) begin
                        // Uses the count including this last position's hit.
                        fail_q  <= (err_cnt_d != deg_q);
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
